// File: rtl/pipe_rr_arbiter_if.sv
// pipe_rr_arbiter_if
// Bundles the requester-side and downstream-side stream signals of the
// round-robin pipeline merge stage.
//   in_valid  [NUM_REQ]        per-requester valid, bit i = requester i
//   in_ready  [NUM_REQ]        per-requester ready, one-hot or zero
//   in_data   [NUM_REQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   out_valid                  output register holds a word
//   out_ready                  downstream accepts the word this cycle
//   out_data  [WIDTH]          registered word
//   out_id    [IDW]            source requester of out_data
// Modports: slave = the arbiter stage, master = the surrounding environment.
interface pipe_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ-1:0]       in_ready;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter
// Merges NUM_REQ valid/ready producers into one registered output stream.
// A combinational round-robin scan starting at ptr picks one valid requester;
// its word and index load into a single-entry output register whenever that
// register is empty or being drained, giving one word per cycle throughput.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipe_rr_arbiter_if.slave (in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data/out_id)
module pipe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_rr_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(NUM_REQ);

  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [IDW-1:0]     out_id_q;
  logic [IDW-1:0]     ptr;

  logic               accept;
  logic               found;
  logic [IDW-1:0]     gnt;
  logic [NUM_REQ-1:0] ready;
  logic               in_xfer;

  assign accept = !out_valid_q || bus.out_ready;

  // Scan from the highest offset down so the lowest offset from ptr, i.e. the
  // first valid requester at or after ptr, is the one left in gnt.
  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.in_valid[idx]) begin
        gnt   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  // Ready is gated by rst so nothing looks accepted while the stage is held in
  // reset (the register reads empty then, which alone would open accept).
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = accept && found && !rst && (gnt == IDW'(i)) && bus.in_valid[i];
    end
  end

  assign in_xfer = |ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr         <= '0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[int'(gnt)*WIDTH +: WIDTH];
      out_id_q    <= gnt;
      ptr         <= (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
module tb_pipe_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic rst;

  pipe_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  pipe_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus state
  logic [N-1:0] vld;
  logic [W-1:0] dat [N];
  logic         ordy;

  // reference model: contents of the output slot and the rotation start
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;
  int           last_gnt;

  // fairness bookkeeping: grants to others since requester i went valid
  int           others [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = dat[i];
    bus.in_valid  = vld;
    bus.out_ready = ordy;
  endtask

  task automatic model_reset();
    m_valid  = 0;
    m_data   = '0;
    m_id     = 0;
    m_ptr    = 0;
    last_gnt = -1;
    for (int i = 0; i < N; i++) others[i] = 0;
  endtask

  // One clock cycle: check the DUT against the model at the falling edge,
  // then advance the model across the rising edge.
  task automatic step(input bit fair = 0);
    int g;
    bit acc;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] gdat;
    drive();
    @(negedge clk);
    acc = !m_valid || ordy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && vld[i]) g = i;
    end
    exp_rdy = '0;
    if (acc && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid && ordy) begin
      chk("out_data", 64'(bus.out_data), 64'(m_data));
      chk("out_id", 64'(bus.out_id), 64'(m_id));
    end
    last_gnt = (acc && g >= 0) ? g : -1;
    gdat = (g >= 0) ? dat[g] : '0;
    if (fair && last_gnt >= 0) begin
      chk("fairness", 64'(others[last_gnt] < N), 64'(1));
      for (int i = 0; i < N; i++)
        if (i == last_gnt) others[i] = 0;
        else if (vld[i]) others[i]++;
    end
    @(posedge clk);
    #1;
    if (last_gnt >= 0) begin
      m_valid = 1;
      m_data  = gdat;
      m_id    = last_gnt;
      m_ptr   = (last_gnt + 1) % N;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    ordy = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst  = 1'b1;
    vld  = '0;
    ordy = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    model_reset();

    // reset holds everything quiet even with all requesters valid
    vld = 4'b1111;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_id", 64'(bus.out_id), 64'(0));
    rst = 1'b0;

    // single requester
    vld = 4'b0100;
    dat[2] = 32'hA5A5_1234;
    ordy = 1'b1;
    drive();
    #1;
    chk("single_in_ready", 64'(bus.in_ready), 64'(4'b0100));
    step();
    vld = '0;
    chk("single_valid", 64'(bus.out_valid), 64'(1));
    chk("single_data", 64'(bus.out_data), 64'(32'hA5A5_1234));
    chk("single_id", 64'(bus.out_id), 64'(2));
    step();

    // round robin over all four, one word per cycle
    do_reset();
    vld = 4'b1111;
    ordy = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = W'(i);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", 64'(bus.out_valid), 64'(1));
      chk("rr_id", 64'(bus.out_id), 64'(k % N));
      chk("rr_data", 64'(bus.out_data), 64'(k % N));
    end

    // backpressure: word from requester 1 held for 3 stalled cycles
    do_reset();
    vld = 4'b0010;
    dat[1] = 32'hDEAD_BEEF;
    dat[0] = 32'h1111_0000;
    dat[2] = 32'h2222_0000;
    dat[3] = 32'h3333_0000;
    ordy = 1'b0;
    step();
    vld = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_data", 64'(bus.out_data), 64'(32'hDEAD_BEEF));
      chk("stall_id", 64'(bus.out_id), 64'(1));
      chk("stall_ready", 64'(bus.in_ready), 64'(0));
    end
    ordy = 1'b1;
    step();
    chk("bp_next_id", 64'(bus.out_id), 64'(2));
    chk("bp_next_data", 64'(bus.out_data), 64'(32'h2222_0000));
    vld = 4'b1001;
    step();

    // idle requesters skipped
    do_reset();
    vld = 4'b1001;
    ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("skip_id", 64'(bus.out_id), 64'((k % 2 == 0) ? 0 : 3));
    end

    // reset in the middle of a held word
    do_reset();
    vld = 4'b1111;
    ordy = 1'b0;
    step();
    step();
    chk("mid_valid_before", 64'(bus.out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid_async", 64'(bus.out_valid), 64'(0));
    chk("mid_ready_async", 64'(bus.in_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    vld = 4'b1010;
    ordy = 1'b1;
    rst = 1'b0;
    step();
    chk("mid_first_id", 64'(bus.out_id), 64'(1));
    step();
    chk("mid_second_id", 64'(bus.out_id), 64'(3));

    // randomized traffic honouring the hold-until-ready contract
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] || last_gnt == i) begin
          if (vld[i]) others[i] = 0;
          vld[i] = 1'($urandom_range(0, 1));
          dat[i] = $urandom;
          if (!vld[i]) others[i] = 0;
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
